// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM / write-port memory arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned RD_ADDR_W = 22;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [ADDR_W-1:0] HDR_OFF_DEFAULT = 24'h000200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT
  } arb_state_e;

  // Command payload presented to the memory controller
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } mem_cmd_t;

endpackage

// File: rtl/rom_mem_arbiter_if.sv
// Command/response bus between the arbiter and the memory controller.
interface rom_mem_arbiter_if
  import rom_arb_pkg::*;
();

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_din,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_din,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/rom_mem_arbiter.sv
// Arbitrates single-byte ROM reads and toggle-handshake 16-bit writes onto one
// memory controller port, bounding how long reads may starve a pending write.
module rom_mem_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned       STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] HDR_OFF      = HDR_OFF_DEFAULT
) (
  input  logic                 clk_ram,
  input  logic                 reset,
  input  logic                 hdr_skip,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ack,
  input  logic                 rd_req,
  input  logic [RD_ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0]    rd_data,
  output logic                 rd_rdy,
  output logic                 rd_ovf,
  rom_mem_arbiter_if.master    mem
);

  localparam int unsigned       STV_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0]  STV_MAX   = STV_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

  arb_state_e        r_state, w_state_nxt;
  mem_cmd_t          r_cmd;
  logic              r_mem_valid;
  logic              r_wr_ack;
  logic              r_rd_rdy;
  logic              r_rd_ovf;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [BYTE_W-1:0] r_rd_data;
  logic [STV_W-1:0]  r_starve;

  logic              w_rd_accept;
  logic              w_rd_want;
  logic              w_wr_pend;
  logic              w_rd_grant;
  logic              w_wr_grant;
  logic [ADDR_W-1:0] w_new_addr;
  logic [ADDR_W-1:0] w_rd_src;

  assign w_new_addr  = ADDR_W'(rd_addr) + (hdr_skip ? HDR_OFF : '0);
  assign w_rd_accept = rd_req & r_rd_rdy;
  // A read arriving this cycle competes in IDLE so the command issues next cycle
  assign w_rd_want   = r_rd_pend | w_rd_accept;
  assign w_rd_src    = r_rd_pend ? r_rd_addr : w_new_addr;
  assign w_wr_pend   = wr_req ^ r_wr_ack;

  // State register
  always_ff @(posedge clk_ram) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and grant decode
  always_comb begin
    w_state_nxt = r_state;
    w_rd_grant  = 1'b0;
    w_wr_grant  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_want && (!w_wr_pend || (r_starve < STV_MAX))) begin
          w_state_nxt = ST_RD_ISSUE;
          w_rd_grant  = 1'b1;
        end else if (w_wr_pend) begin
          w_state_nxt = ST_WR_ISSUE;
          w_wr_grant  = 1'b1;
        end
      end
      ST_RD_ISSUE: if (mem.mem_ready)  w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  if (mem.mem_rvalid) w_state_nxt = ST_IDLE;
      ST_WR_ISSUE: if (mem.mem_ready)  w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT:  w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath and handshake outputs
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_cmd       <= '0;
      r_mem_valid <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_rdy    <= 1'b1;
      r_rd_ovf    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_starve    <= '0;
    end else begin
      r_mem_valid <= (w_state_nxt == ST_RD_ISSUE) || (w_state_nxt == ST_WR_ISSUE);

      if (w_rd_accept) begin
        r_rd_rdy  <= 1'b0;
        r_rd_addr <= w_new_addr;
      end
      if (rd_req && !r_rd_rdy) r_rd_ovf <= 1'b1;

      if (w_rd_grant)       r_rd_pend <= 1'b0;
      else if (w_rd_accept) r_rd_pend <= 1'b1;

      if (w_rd_grant) begin
        r_cmd.we   <= 1'b0;
        r_cmd.addr <= w_rd_src & WORD_MASK;
      end else if (w_wr_grant) begin
        r_cmd.we   <= 1'b1;
        r_cmd.addr <= wr_addr & WORD_MASK;
        r_cmd.din  <= wr_data;
      end

      // Posted write: acknowledge as soon as the controller takes the command
      if ((r_state == ST_WR_ISSUE) && mem.mem_ready) r_wr_ack <= ~r_wr_ack;

      if ((r_state == ST_RD_WAIT) && mem.mem_rvalid) begin
        r_rd_data <= r_rd_addr[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
        r_rd_rdy  <= 1'b1;
      end

      if (!w_wr_pend || w_wr_grant)             r_starve <= '0;
      else if (w_rd_grant && r_starve < STV_MAX) r_starve <= r_starve + STV_W'(1);
    end
  end

  assign wr_ack        = r_wr_ack;
  assign rd_data       = r_rd_data;
  assign rd_rdy        = r_rd_rdy;
  assign rd_ovf        = r_rd_ovf;
  assign mem.mem_valid = r_mem_valid;
  assign mem.mem_we    = r_cmd.we;
  assign mem.mem_addr  = r_cmd.addr;
  assign mem.mem_din   = r_cmd.din;

endmodule

// File: tb/tb_rom_mem_arbiter.sv
// Directed bench for rom_mem_arbiter: read vector table plus write-stall,
// starvation, overflow and mid-read reset sequences.
module tb_rom_mem_arbiter;
  import rom_arb_pkg::*;

  logic        clk_ram = 1'b0;
  logic        reset;
  logic        hdr_skip;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [21:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_rdy;
  logic        rd_ovf;

  int total = 0;
  int bad   = 0;
  logic order_q[$];

  always #5 clk_ram = ~clk_ram;

  rom_mem_arbiter_if mif();

  rom_mem_arbiter #(.STARVE_LIMIT(4), .HDR_OFF(24'h000200)) dut (
    .clk_ram (clk_ram),
    .reset   (reset),
    .hdr_skip(hdr_skip),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_rdy  (rd_rdy),
    .rd_ovf  (rd_ovf),
    .mem     (mif)
  );

  // Log every accepted memory command (1 = write, 0 = read)
  always @(posedge clk_ram)
    if (!reset && mif.mem_valid && mif.mem_ready) order_q.push_back(mif.mem_we);

  typedef struct {
    logic [21:0] addr;
    logic        hs;
    logic [15:0] rdata;
    logic [23:0] exp_maddr;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // One read with the bench acting as controller: rvalid two cycles after accept
  task automatic rd_txn(input logic [21:0] a, input logic [15:0] rdata, output logic [7:0] got);
    int   cnt;
    logic done;
    cnt  = -1;
    done = 1'b0;
    rd_req = 1'b1; rd_addr = a; hdr_skip = 1'b0;
    step();
    rd_req = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      mif.mem_rvalid = 1'b0;
      if (rd_rdy) done = 1'b1;
      else begin
        if (cnt == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = rdata;
          cnt = -1;
        end else if (cnt > 0) cnt--;
        if (mif.mem_valid && mif.mem_ready && !mif.mem_we) cnt = 1;
        step();
      end
    end
    got = rd_data;
    if (!done) chk("rd_txn_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic       exp_order[7];
    logic       ov;

    vecs[0] = '{22'h000005, 1'b0, 16'hA55A, 24'h000004, 8'hA5};
    vecs[1] = '{22'h000010, 1'b1, 16'h1234, 24'h000210, 8'h34};
    vecs[2] = '{22'h3FFFFF, 1'b1, 16'hBEEF, 24'h4001FE, 8'hBE};
    vecs[3] = '{22'h000000, 1'b0, 16'h00FF, 24'h000000, 8'hFF};
    vecs[4] = '{22'h000203, 1'b0, 16'h7788, 24'h000202, 8'h77};
    vecs[5] = '{22'h0001F1, 1'b1, 16'h6B2C, 24'h0003F0, 8'h6B};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; hdr_skip = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    mif.mem_ready = 1'b1; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    repeat (3) step();

    chk("rst_wr_ack",    32'(wr_ack), 32'd0);
    chk("rst_rd_rdy",    32'(rd_rdy), 32'd1);
    chk("rst_rd_data",   32'(rd_data), 32'd0);
    chk("rst_rd_ovf",    32'(rd_ovf), 32'd0);
    chk("rst_mem_valid", 32'(mif.mem_valid), 32'd0);
    chk("rst_mem_we",    32'(mif.mem_we), 32'd0);
    chk("rst_mem_addr",  32'(mif.mem_addr), 32'd0);
    chk("rst_mem_din",   32'(mif.mem_din), 32'd0);
    reset = 1'b0;
    step();

    // Table: issue latency, address offset/alignment, byte select
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; rd_addr = vecs[i].addr; hdr_skip = vecs[i].hs;
      step();
      rd_req = 1'b0;
      chk("vec_issue_valid", 32'(mif.mem_valid), 32'd1);
      chk("vec_mem_addr",    32'(mif.mem_addr), 32'(vecs[i].exp_maddr));
      chk("vec_mem_we",      32'(mif.mem_we), 32'd0);
      chk("vec_rdy_low",     32'(rd_rdy), 32'd0);
      step();
      chk("vec_valid_drop",  32'(mif.mem_valid), 32'd0);
      step();
      mif.mem_rvalid = 1'b1; mif.mem_rdata = vecs[i].rdata;
      chk("vec_rdy_wait",    32'(rd_rdy), 32'd0);
      step();
      mif.mem_rvalid = 1'b0;
      chk("vec_rd_data",     32'(rd_data), 32'(vecs[i].exp_byte));
      chk("vec_rd_rdy",      32'(rd_rdy), 32'd1);
    end

    // Write held off by mem_ready low for 10 cycles
    order_q.delete();
    mif.mem_ready = 1'b0;
    wr_addr = 24'h123457; wr_data = 16'hCAFE; wr_req = ~wr_req;
    step();
    for (int c = 0; c < 10; c++) begin
      chk("wr_stall_valid", 32'(mif.mem_valid), 32'd1);
      chk("wr_stall_addr",  32'(mif.mem_addr), 32'h123456);
      chk("wr_stall_din",   32'(mif.mem_din), 32'hCAFE);
      chk("wr_stall_we",    32'(mif.mem_we), 32'd1);
      chk("wr_stall_ack",   32'(wr_ack), 32'd0);
      if (c < 9) step();
    end
    mif.mem_ready = 1'b1;
    step();
    chk("wr_ack_toggle", 32'(wr_ack), 32'd1);
    chk("wr_valid_drop", 32'(mif.mem_valid), 32'd0);
    repeat (3) step();
    chk("wr_ack_once",   32'(wr_ack), 32'd1);
    chk("wr_cmd_count",  32'(order_q.size()), 32'd1);

    // Starvation: write pending alongside six back-to-back reads
    order_q.delete();
    wr_addr = 24'h000100; wr_data = 16'h1111; wr_req = ~wr_req;
    for (int i = 0; i < 6; i++) begin
      rd_txn(22'(i * 2), {8'hF0, 8'(i)}, got);
      chk("starve_rd_data", 32'(got), 32'(i));
    end
    chk("starve_cmd_count", 32'(order_q.size()), 32'd7);
    for (int j = 0; j < 7; j++) begin
      ov = (j < order_q.size()) ? order_q[j] : 1'bx;
      chk("starve_order", 32'(ov), 32'(exp_order[j]));
    end
    chk("starve_wr_ack", 32'(wr_ack), 32'(wr_req));
    chk("starve_no_ovf", 32'(rd_ovf), 32'd0);

    // Overflow: second rd_req while busy is dropped
    order_q.delete();
    rd_req = 1'b1; rd_addr = 22'h000021; hdr_skip = 1'b0;
    step();
    rd_addr = 22'h000040;
    step();
    rd_req = 1'b0;
    chk("ovf_set", 32'(rd_ovf), 32'd1);
    step();
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 16'h9C3E;
    step();
    mif.mem_rvalid = 1'b0;
    chk("ovf_rd_data", 32'(rd_data), 32'h9C);
    chk("ovf_rd_rdy",  32'(rd_rdy), 32'd1);
    repeat (4) step();
    chk("ovf_one_read", 32'(order_q.size()), 32'd1);
    chk("ovf_sticky",   32'(rd_ovf), 32'd1);

    // Reset while waiting for read data; late rvalid must be discarded
    rd_req = 1'b1; rd_addr = 22'h000007;
    step();
    rd_req = 1'b0;
    step();
    chk("rst_mid_busy", 32'(rd_rdy), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_rdy",   32'(rd_rdy), 32'd1);
    chk("rst_mid_data",  32'(rd_data), 32'd0);
    chk("rst_mid_ovf",   32'(rd_ovf), 32'd0);
    chk("rst_mid_valid", 32'(mif.mem_valid), 32'd0);
    step();
    mif.mem_rvalid = 1'b1; mif.mem_rdata = 16'h5A5A;
    step();
    mif.mem_rvalid = 1'b0;
    chk("late_rv_data",  32'(rd_data), 32'd0);
    chk("late_rv_rdy",   32'(rd_rdy), 32'd1);
    repeat (2) step();
    chk("late_rv_idle",  32'(mif.mem_valid), 32'd0);
    rd_txn(22'h000003, 16'h4321, got);
    chk("post_rst_read", 32'(got), 32'h43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_mem_arbiter.md
ROM_MEM_ARBITER -- requirements
Module: rom_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning max consecutive read grants while a write is pending.
REQ-002 Parameter HDR_OFF, default 24'h000200, meaning address offset added when hdr_skip=1.
REQ-003 clk_ram  in  1  clock, all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 hdr_skip  in  1  add HDR_OFF to read addresses.
REQ-006 wr_req  in  1  toggle; a write is pending while wr_req != wr_ack.
REQ-007 wr_addr  in  24  byte address of 16-bit write word (bit 0 ignored).
REQ-008 wr_data  in  16  write word.
REQ-009 wr_ack  out  1  toggle; completes the write handshake.
REQ-010 rd_req  in  1  one-cycle pulse requesting one ROM byte.
REQ-011 rd_addr  in  22  ROM byte address.
REQ-012 rd_data  out  8  returned byte, held until next read completes.
REQ-013 rd_rdy  out  1  high = idle/data valid; low from read accept to data return.
REQ-014 rd_ovf  out  1  sticky: rd_req arrived while rd_rdy low.
REQ-015 mem_valid  out  1  command valid to memory controller.
REQ-016 mem_ready  in  1  controller accepts command when mem_valid & mem_ready.
REQ-017 mem_we  out  1  1 = write, 0 = read.
REQ-018 mem_addr  out  24  word-aligned address (bit 0 = 0).
REQ-019 mem_din  out  16  write data.
REQ-020 mem_rvalid  in  1  one-cycle read data strobe.
REQ-021 mem_rdata  in  16  read word; [7:0] even byte, [15:8] odd byte.

Function
REQ-022 FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
REQ-023 rd_req with rd_rdy high: latch address (rd_addr + (hdr_skip ? HDR_OFF : 0), 24-bit, no wrap beyond 24 bits) and byte select, clear rd_rdy next cycle, set read-pending.
REQ-024 IDLE: read-pending and (no write pending or starve count < STARVE_LIMIT) -> RD_ISSUE; else write pending -> WR_ISSUE; else stay.
REQ-025 Simultaneous new rd_req and pending write in IDLE: read wins unless starve count == STARVE_LIMIT.
REQ-026 Starve counter increments per read grant while a write is pending, saturates at STARVE_LIMIT, clears on write grant or when no write pending.
REQ-027 RD_ISSUE/WR_ISSUE: mem_valid=1, mem_addr/mem_we/mem_din stable until mem_ready sampled high; then -> RD_WAIT/WR_WAIT, mem_valid=0 next cycle.
REQ-028 Latency: rd_req in IDLE with free memory at cycle n -> mem_valid at n+1.
REQ-029 RD_WAIT: mem_rvalid at cycle m -> rd_data = selected byte and rd_rdy=1 at m+1; -> IDLE.
REQ-030 WR_ISSUE accept at cycle k -> WR_WAIT -> wr_ack toggles at k+1 (posted write); -> IDLE.
REQ-031 wr_addr/wr_data sampled on entry to WR_ISSUE; source holds them until wr_ack toggles.
REQ-032 rd_req while rd_rdy low: ignored, rd_ovf set; cleared only by reset.
REQ-033 mem_rvalid outside RD_WAIT: ignored.
REQ-034 At most one outstanding memory command at any time.

Reset
REQ-035 Reset outputs: wr_ack=0, rd_rdy=1, rd_data=0, rd_ovf=0, mem_valid=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-036 Reset mid-operation: FSM -> IDLE next cycle, pending read and starve count cleared, in-flight mem_rvalid discarded.

Structure
REQ-037 Shared package rom_arb_pkg holds FSM state enum and HDR_OFF default constant.
REQ-038 Single module; no sub-modules.

Verification
REQ-039 rd_req addr 0x000005, hdr_skip=0, mem_ready=1, mem_rdata=0xA55A 3 cycles later -> mem_addr=0x000004, rd_data=0xA5, rd_rdy high one cycle after mem_rvalid.
REQ-040 hdr_skip=1, rd_addr 0x000010 -> mem_addr=0x000210, even byte returned.
REQ-041 Write pending, 6 back-to-back reads -> exactly 4 reads granted, then write, wr_ack toggles, then remaining reads.
REQ-042 mem_ready held low 10 cycles during WR_ISSUE -> mem_valid/mem_addr/mem_din stable all 10 cycles, wr_ack toggles once after acceptance.
REQ-043 Second rd_req while rd_rdy low -> rd_ovf=1, only one memory read issued.
REQ-044 Reset asserted in RD_WAIT, later mem_rvalid -> rd_rdy=1, rd_data=0 unchanged, FSM IDLE.
